seven_seg_scan_controller: RTL

Time-multiplexed scan controller that shares one combinational hex-to-seven-segment decoder among NUM_DIGITS common-anode digits. Each cycle it presents one digit's nibble to the shared decoder's X3..X0 inputs and drives the matching active-low digit enable. It inserts a blanking interval at every digit change to prevent ghosting. New display contents are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_scan_controller.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_scan_controller
//  Description : Time-multiplexed scan controller for NUM_DIGITS common-anode
//                seven-segment digits sharing one hex decoder. Each digit slot
//                starts with a blanking interval (anti-ghosting). New contents
//                are double-buffered and committed only at frame boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_controller #(
    parameter int NUM_DIGITS = 4,       // scanned digits, 2..8
    parameter int PRESCALE   = 50000,   // clock cycles per digit slot (> BLANK)
    parameter int BLANK      = 16       // dark cycles at the start of each slot
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic [4*NUM_DIGITS-1:0]   Data,
    input  logic [NUM_DIGITS-1:0]     Blank_in,
    input  logic                      Load,
    output logic                      Busy,
    output logic                      Ack,
    output logic                      Frame,
    output logic [3:0]                Nibble,
    output logic [NUM_DIGITS-1:0]     Digit_n
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0]        r_cnt;           // cycle within the current slot
    logic [c_IDX_W-1:0]        r_idx;           // digit currently scanned
    logic [4*NUM_DIGITS-1:0]   r_active_data;   // contents being displayed
    logic [NUM_DIGITS-1:0]     r_active_mask;   // 1 = digit kept dark
    logic [4*NUM_DIGITS-1:0]   r_stage_data;    // captured, not yet shown
    logic [NUM_DIGITS-1:0]     r_stage_mask;
    logic                      r_pending;       // staging holds an update
    logic                      r_ack;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                      w_slot_end;
    logic                      w_frame_end;
    logic                      w_commit;
    logic                      w_accept;
    logic                      w_blank_phase;
    logic [3:0]                w_nibble;
    logic [NUM_DIGITS-1:0]     w_digit_n;

    assign w_slot_end  = (r_cnt == c_CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == c_IDX_LAST);
    // Commit only sees updates captured on earlier edges; a Load landing on
    // the frame-end edge waits a whole frame because r_pending is still 0.
    assign w_commit    = w_frame_end && r_pending;
    assign w_accept    = Load && !r_pending;

    // A zero-length blanking interval needs no comparator at all.
    generate
        if (BLANK == 0) begin : g_blank_none
            assign w_blank_phase = 1'b0;
        end else begin : g_blank_cmp
            localparam logic [c_CNT_W-1:0] c_BLANK_CNT = c_CNT_W'(BLANK);
            assign w_blank_phase = (r_cnt < c_BLANK_CNT);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Slot counter and digit index: cnt runs 0..PRESCALE-1, idx advances and
    // wraps at each slot end.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            if (r_idx == c_IDX_LAST) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Staging buffer: capture a new update whenever nothing is pending; a Load
    // seen while busy is silently dropped.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_stage_data <= '0;
            r_stage_mask <= '0;
        end else if (w_accept) begin
            r_stage_data <= Data;
            r_stage_mask <= Blank_in;
        end
    end

    // ------------------------------------------------------------------------
    // Pending flag: set on acceptance, cleared on commit. The two can never
    // coincide because acceptance needs pending low and commit needs it high.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
        end else if (w_commit) begin
            r_pending <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Active buffer: swapped in only at a frame boundary so one frame never
    // mixes old and new digits. Reset leaves the display fully dark.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_active_data <= '0;
            r_active_mask <= '1;
        end else if (w_commit) begin
            r_active_data <= r_stage_data;
            r_active_mask <= r_stage_mask;
        end
    end

    // ------------------------------------------------------------------------
    // Commit acknowledge: single-cycle pulse in the first cycle of the frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= w_commit;
        end
    end

    // ------------------------------------------------------------------------
    // Nibble mux: present the active digit's value during the whole slot,
    // including the blanking phase, so the decoder output settles early.
    // ------------------------------------------------------------------------
    always_comb begin
        w_nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_nibble = r_active_data[4*k +: 4];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Digit enables: all off while blanking; in the drive phase only the
    // scanned digit is pulled low, and only if its mask bit is clear.
    // ------------------------------------------------------------------------
    always_comb begin
        w_digit_n = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((r_idx == c_IDX_W'(k)) && !w_blank_phase && !r_active_mask[k]) begin
                w_digit_n[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (register-decoded only)
    // ------------------------------------------------------------------------
    assign Busy    = r_pending;
    assign Ack     = r_ack;
    assign Frame   = (r_idx == '0) && (r_cnt == '0);
    assign Nibble  = w_nibble;
    assign Digit_n = w_digit_n;

endmodule
`default_nettype wire
